// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - state encoding and width helpers for the direct-mapped block cache
package cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_REFILL,
      ST_WRITE,
      ST_RESP
   } state_t;

   function automatic int index_width(input int cache_size);
      return (cache_size > 1) ? $clog2(cache_size) : 1;
   endfunction

   function automatic int word_addr_width(input int tag_width, input int offset_width);
      return tag_width + offset_width;
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - data/tag/valid arrays with one write port and combinational read
module cache_line_store
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int TAG_WIDTH    = 16,
   parameter int CACHE_SIZE   = 16,
   parameter int BLOCK_SIZE   = 4,
   parameter int OFFSET_WIDTH = 2,
   parameter int INDEX_WIDTH  = index_width(CACHE_SIZE)
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [INDEX_WIDTH-1:0]  index,
   input  logic                    word_we,
   input  logic [OFFSET_WIDTH-1:0] wr_offset,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    line_we,
   input  logic [TAG_WIDTH-1:0]    wr_tag,
   input  logic                    clr_valid,
   input  logic [OFFSET_WIDTH-1:0] rd_offset,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic [TAG_WIDTH-1:0]    rd_tag,
   output logic                    rd_valid
);

   logic [DATA_WIDTH-1:0] data_mem [CACHE_SIZE][BLOCK_SIZE];
   logic [TAG_WIDTH-1:0]  tag_mem  [CACHE_SIZE];
   logic [CACHE_SIZE-1:0] valid_q;

   // Only the valid bits need reset; tag/data are meaningless while invalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else if (line_we) begin
         valid_q[index] <= 1'b1;
      end else if (clr_valid) begin
         valid_q[index] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (word_we) begin
         data_mem[index][wr_offset] <= wr_data;
      end
      if (line_we) begin
         tag_mem[index] <= wr_tag;
      end
   end

   assign rd_data  = data_mem[index][rd_offset];
   assign rd_tag   = tag_mem[index];
   assign rd_valid = valid_q[index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-through cache controller with block refill over req/ack memory
module dm_cache_ctrl
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int TAG_WIDTH    = 16,
   parameter int CACHE_SIZE   = 16,
   parameter int BLOCK_SIZE   = 4,
   parameter int OFFSET_WIDTH = 2
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              cpu_req,
   input  logic                              cpu_we,
   input  logic [TAG_WIDTH-1:0]              cpu_tag,
   input  logic [OFFSET_WIDTH-1:0]           cpu_offset,
   input  logic [DATA_WIDTH-1:0]             cpu_wdata,
   output logic                              cpu_ready,
   output logic                              cpu_done,
   output logic [DATA_WIDTH-1:0]             cpu_rdata,
   output logic                              cpu_hit,
   output logic                              cpu_miss,
   output logic                              mem_req,
   output logic                              mem_we,
   output logic [TAG_WIDTH+OFFSET_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]             mem_wdata,
   input  logic                              mem_ack,
   input  logic [DATA_WIDTH-1:0]             mem_rdata,
   output logic [31:0]                       hit_counter,
   output logic [31:0]                       miss_counter,
   output logic [31:0]                       total_requests
);

   localparam int INDEX_WIDTH = index_width(CACHE_SIZE);
   localparam int ADDR_WIDTH  = word_addr_width(TAG_WIDTH, OFFSET_WIDTH);
   localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = OFFSET_WIDTH'(BLOCK_SIZE - 1);

   state_t                  state;
   logic [TAG_WIDTH-1:0]    cur_tag;
   logic [OFFSET_WIDTH-1:0] cur_offset;
   logic                    cur_we;
   logic [DATA_WIDTH-1:0]   cur_wdata;
   logic [OFFSET_WIDTH-1:0] word_cnt;
   logic                    hit_q;

   logic [INDEX_WIDTH-1:0]  index;
   logic [DATA_WIDTH-1:0]   st_data;
   logic [TAG_WIDTH-1:0]    st_tag;
   logic                    st_valid;
   logic                    lookup_hit;
   logic                    refill_ack;
   logic                    word_we;
   logic                    line_we;
   logic                    clr_valid;
   logic [OFFSET_WIDTH-1:0] wr_offset;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [ADDR_WIDTH-1:0]   refill_addr;
   logic [ADDR_WIDTH-1:0]   write_addr;

   assign index      = cur_tag[INDEX_WIDTH-1:0];
   assign lookup_hit = st_valid && (st_tag == cur_tag);
   assign refill_ack = (state == ST_REFILL) && mem_ack;

   // Write hits update the line during LOOKUP; refill words land as each ack arrives.
   assign word_we   = refill_ack || ((state == ST_LOOKUP) && cur_we && lookup_hit);
   assign line_we   = refill_ack && (word_cnt == LAST_WORD);
   assign clr_valid = (state == ST_LOOKUP) && !cur_we && !lookup_hit;
   assign wr_offset = (state == ST_REFILL) ? word_cnt : cur_offset;
   assign wr_data   = (state == ST_REFILL) ? mem_rdata : cur_wdata;

   cache_line_store #(
      .DATA_WIDTH   (DATA_WIDTH),
      .TAG_WIDTH    (TAG_WIDTH),
      .CACHE_SIZE   (CACHE_SIZE),
      .BLOCK_SIZE   (BLOCK_SIZE),
      .OFFSET_WIDTH (OFFSET_WIDTH),
      .INDEX_WIDTH  (INDEX_WIDTH)
   ) u_store (
      .clk       (clk),
      .reset     (reset),
      .index     (index),
      .word_we   (word_we),
      .wr_offset (wr_offset),
      .wr_data   (wr_data),
      .line_we   (line_we),
      .wr_tag    (cur_tag),
      .clr_valid (clr_valid),
      .rd_offset (cur_offset),
      .rd_data   (st_data),
      .rd_tag    (st_tag),
      .rd_valid  (st_valid)
   );

   // Memory-side outputs follow the state register, so reset drops them at once.
   assign refill_addr = {cur_tag, word_cnt};
   assign write_addr  = {cur_tag, cur_offset};
   assign cpu_ready   = (state == ST_IDLE);
   assign mem_req     = (state == ST_REFILL) || (state == ST_WRITE);
   assign mem_we      = (state == ST_WRITE);
   assign mem_addr    = (state == ST_REFILL) ? refill_addr :
                        (state == ST_WRITE)  ? write_addr  : '0;
   assign mem_wdata   = (state == ST_WRITE) ? cur_wdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         cur_tag        <= '0;
         cur_offset     <= '0;
         cur_we         <= 1'b0;
         cur_wdata      <= '0;
         word_cnt       <= '0;
         hit_q          <= 1'b0;
         cpu_done       <= 1'b0;
         cpu_hit        <= 1'b0;
         cpu_miss       <= 1'b0;
         cpu_rdata      <= '0;
         hit_counter    <= '0;
         miss_counter   <= '0;
         total_requests <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  cur_tag        <= cpu_tag;
                  cur_offset     <= cpu_offset;
                  cur_we         <= cpu_we;
                  cur_wdata      <= cpu_wdata;
                  total_requests <= total_requests + 32'd1;
                  state          <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               hit_q <= lookup_hit;
               if (lookup_hit) hit_counter  <= hit_counter + 32'd1;
               else            miss_counter <= miss_counter + 32'd1;
               if (cur_we) begin
                  state <= ST_WRITE;
               end else if (lookup_hit) begin
                  cpu_done  <= 1'b1;
                  cpu_hit   <= 1'b1;
                  cpu_miss  <= 1'b0;
                  cpu_rdata <= st_data;
                  state     <= ST_RESP;
               end else begin
                  word_cnt <= '0;
                  state    <= ST_REFILL;
               end
            end
            ST_REFILL: begin
               if (mem_ack) begin
                  word_cnt <= word_cnt + OFFSET_WIDTH'(1);
                  if (word_cnt == LAST_WORD) begin
                     // The requested word may be the one arriving on this very ack.
                     cpu_rdata <= (cur_offset == word_cnt) ? mem_rdata : st_data;
                     cpu_done  <= 1'b1;
                     cpu_hit   <= hit_q;
                     cpu_miss  <= !hit_q;
                     state     <= ST_RESP;
                  end
               end
            end
            ST_WRITE: begin
               if (mem_ack) begin
                  cpu_rdata <= '0;
                  cpu_done  <= 1'b1;
                  cpu_hit   <= hit_q;
                  cpu_miss  <= !hit_q;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               cpu_done <= 1'b0;
               cpu_hit  <= 1'b0;
               cpu_miss <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - self-checking bench for dm_cache_ctrl against a line-level cache model
module tb_dm_cache_ctrl;

   localparam int DW = 16;
   localparam int TW = 16;
   localparam int CS = 16;
   localparam int BS = 4;
   localparam int OW = 2;
   localparam int AW = TW + OW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [TW-1:0] cpu_tag = '0;
   logic [OW-1:0] cpu_offset = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ready, cpu_done, cpu_hit, cpu_miss;
   logic [DW-1:0] cpu_rdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic [31:0]   hit_counter, miss_counter, total_requests;

   always #5 clk = ~clk;

   dm_cache_ctrl #(
      .DATA_WIDTH(DW), .TAG_WIDTH(TW), .CACHE_SIZE(CS), .BLOCK_SIZE(BS), .OFFSET_WIDTH(OW)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_tag(cpu_tag), .cpu_offset(cpu_offset),
      .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .cpu_hit(cpu_hit), .cpu_miss(cpu_miss),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_counter(hit_counter), .miss_counter(miss_counter), .total_requests(total_requests)
   );

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Memory seen by the bus (responder) and the memory the model believes in; both default to word address.
   logic [DW-1:0] mem     [logic [AW-1:0]];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      return mem.exists(a) ? mem[a] : a[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : a[DW-1:0];
   endfunction

   logic [AW:0]   log_op[$];
   logic [DW-1:0] log_wd[$];
   int            ack_delay = 0;
   bit            stray_en = 1'b0;
   int            stab_viol = 0;

   initial begin : responder
      int            wait_cnt;
      bit            pend;
      logic [AW-1:0] paddr;
      logic [DW-1:0] pwd;
      wait_cnt = 0;
      pend = 1'b0;
      paddr = '0;
      pwd = '0;
      forever begin
         @(negedge clk);
         if (mem_req === 1'b1) begin
            if (pend && (mem_addr !== paddr || mem_wdata !== pwd)) stab_viol++;
            paddr = mem_addr;
            pwd = mem_wdata;
            if (wait_cnt >= ack_delay) begin
               mem_ack = 1'b1;
               mem_rdata = mem_rd(mem_addr);
               log_op.push_back({mem_we, mem_addr});
               log_wd.push_back(mem_wdata);
               if (mem_we) mem[mem_addr] = mem_wdata;
               wait_cnt = 0;
               pend = 1'b0;
            end else begin
               mem_ack = 1'b0;
               wait_cnt++;
               pend = 1'b1;
            end
         end else begin
            mem_ack = stray_en ? 1'($urandom_range(1, 0)) : 1'b0;
            mem_rdata = 16'($urandom);
            wait_cnt = 0;
            pend = 1'b0;
         end
      end
   end

   bit          ref_valid [CS];
   logic [TW-1:0] ref_tag [CS];
   int unsigned exp_hits = 0;
   int unsigned exp_miss = 0;
   int unsigned exp_total = 0;
   logic [DW-1:0] obs_rdata;

   task automatic model_reset();
      for (int i = 0; i < CS; i++) ref_valid[i] = 1'b0;
      exp_hits = 0;
      exp_miss = 0;
      exp_total = 0;
   endtask

   task automatic do_req(input bit we, input logic [TW-1:0] tag, input logic [OW-1:0] off,
                         input logic [DW-1:0] wd, input bit pulse_mid);
      logic [3:0]    idx;
      bit            exp_hit;
      logic [AW-1:0] a;
      logic [DW-1:0] exp_rd;
      logic [AW:0]   exp_ops[$];
      logic [DW-1:0] exp_wd[$];
      int            exp_lat, lat, ready_hi, base, n;
      bit            done;
      idx = tag[3:0];
      a = {tag, off};
      exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
      exp_rd = ref_rd(a);
      if (we) begin
         exp_ops.push_back({1'b1, a});
         exp_wd.push_back(wd);
         exp_lat = 2 + (ack_delay + 1);
      end else if (!exp_hit) begin
         for (int k = 0; k < BS; k++) begin
            exp_ops.push_back({1'b0, tag, OW'(k)});
            exp_wd.push_back('0);
         end
         exp_lat = 2 + BS * (ack_delay + 1);
      end else begin
         exp_lat = 2;
      end

      @(negedge clk);
      n = 0;
      while (cpu_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_req", 64'(cpu_ready), 64'(1));
      base = log_op.size();
      cpu_req = 1'b1;
      cpu_we = we;
      cpu_tag = tag;
      cpu_offset = off;
      cpu_wdata = wd;
      @(posedge clk);
      #1 cpu_req = 1'b0;

      lat = 0;
      ready_hi = 0;
      done = 1'b0;
      while (!done && lat < 400) begin
         @(negedge clk);
         lat++;
         if (cpu_done === 1'b1) begin
            done = 1'b1;
            obs_rdata = cpu_rdata;
         end else begin
            if (pulse_mid && lat == 3) begin
               cpu_req = 1'b1;
               cpu_we = 1'b0;
               cpu_tag = tag + 16'h0001;
            end else begin
               cpu_req = 1'b0;
            end
         end
         if (cpu_ready !== 1'b0) ready_hi++;
      end
      cpu_req = 1'b0;

      exp_total++;
      if (exp_hit) exp_hits++;
      else         exp_miss++;
      if (we) ref_mem[a] = wd;
      else if (!exp_hit) begin
         ref_valid[idx] = 1'b1;
         ref_tag[idx] = tag;
      end

      check("done_seen", 64'(done), 64'(1));
      check("latency", 64'(lat), 64'(exp_lat));
      check("ready_low_busy", 64'(ready_hi), 64'(0));
      check("cpu_hit", 64'(cpu_hit), 64'(exp_hit));
      check("cpu_miss", 64'(cpu_miss), 64'(!exp_hit));
      if (!we) check("cpu_rdata", 64'(obs_rdata), 64'(exp_rd));
      check("hit_counter", 64'(hit_counter), 64'(exp_hits));
      check("miss_counter", 64'(miss_counter), 64'(exp_miss));
      check("total_requests", 64'(total_requests), 64'(exp_total));
      check("mem_op_count", 64'(log_op.size() - base), 64'(exp_ops.size()));
      for (int i = 0; i < exp_ops.size(); i++) begin
         if (base + i < log_op.size()) begin
            check("mem_op", 64'(log_op[base+i]), 64'(exp_ops[i]));
            if (exp_ops[i][AW]) check("mem_wdata", 64'(log_wd[base+i]), 64'(exp_wd[i]));
         end
      end
   endtask

   initial begin : stimulus
      int            base, n;
      logic [TW-1:0] t;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_ready", 64'(cpu_ready), 64'(1));
      check("rst_done", 64'(cpu_done), 64'(0));
      check("rst_hit_miss", 64'({cpu_hit, cpu_miss}), 64'(0));
      check("rst_rdata", 64'(cpu_rdata), 64'(0));
      check("rst_mem", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'(0));
      check("rst_counters", 64'(hit_counter | miss_counter | total_requests), 64'(0));
      reset = 1'b0;

      do_req(1'b0, 16'h0010, 2'd1, '0, 1'b0);
      check("tp_miss_rdata", 64'(obs_rdata), 64'h0041);
      check("tp_miss_count", 64'(miss_counter), 64'd1);
      check("tp_total", 64'(total_requests), 64'd1);
      do_req(1'b0, 16'h0010, 2'd2, '0, 1'b0);
      check("tp_hit_rdata", 64'(obs_rdata), 64'h0042);
      check("tp_hit_count", 64'(hit_counter), 64'd1);
      do_req(1'b0, 16'h0020, 2'd0, '0, 1'b0);
      check("tp_evict_rdata", 64'(obs_rdata), 64'h0080);
      do_req(1'b0, 16'h0010, 2'd1, '0, 1'b0);
      check("tp_evict_misses", 64'(miss_counter), 64'd3);

      do_req(1'b0, 16'h0020, 2'd0, '0, 1'b0);
      do_req(1'b1, 16'h0020, 2'd3, 16'hCCCC, 1'b0);
      do_req(1'b0, 16'h0020, 2'd3, '0, 1'b0);
      check("tp_write_hit_rdata", 64'(obs_rdata), 64'hCCCC);
      do_req(1'b1, 16'h0030, 2'd3, 16'h3333, 1'b0);
      do_req(1'b0, 16'h0020, 2'd3, '0, 1'b0);
      check("tp_no_alloc_hit", 64'(cpu_hit), 64'(1));

      ack_delay = 3;
      do_req(1'b0, 16'h0051, 2'd2, '0, 1'b1);
      do_req(1'b1, 16'h0051, 2'd0, 16'hA5A5, 1'b1);
      check("slow_stable", 64'(stab_viol), 64'(0));

      ack_delay = 0;
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_tag = 16'h0062;
      cpu_offset = 2'd0;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      base = log_op.size();
      n = 0;
      while (log_op.size() < base + 2 && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      check("abort_two_words", 64'(log_op.size() - base), 64'(2));
      reset = 1'b1;
      #1;
      check("abort_mem_req", 64'(mem_req), 64'(0));
      check("abort_ready", 64'(cpu_ready), 64'(1));
      check("abort_counters", 64'({hit_counter, miss_counter} | 64'(total_requests)), 64'(0));
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      do_req(1'b0, 16'h0062, 2'd3, '0, 1'b0);
      check("abort_refetch_miss", 64'(cpu_miss), 64'(1));

      stray_en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         ack_delay = $urandom_range(2, 0);
         t = {10'h000, 2'($urandom_range(2, 0)), 4'($urandom_range(3, 0))};
         do_req($urandom_range(9, 0) < 3, t, 2'($urandom), 16'($urandom), 1'b0);
      end
      check("final_stable", 64'(stab_viol), 64'(0));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
